alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational ALU. It grants one requester per cycle with round-robin priority and registers the accepted operands into an execute stage that drives the ALU. It then captures the result and sanitized flags into a response register with a valid/ready handshake. It sits between the ALU and its clients (e.g. the execute unit and the address/branch unit).

---
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared ALU.
// Accepted ops flow ISSUE -> EXEC (drives ALU) -> RSP (valid/ready).
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_func_e;

endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [3:0]        rsp0_flags,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_func,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [3:0]        rsp1_flags,

  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [2:0]        alu_func,
  output logic              alu_output_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_carry,
  input  logic              alu_overflow
);

  logic              exec_valid;
  logic [DATA_W-1:0] exec_a;
  logic [DATA_W-1:0] exec_b;
  alu_func_e         exec_func;
  logic              exec_owner;

  logic              rsp_valid;
  logic              rsp_owner;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;

  logic              last_grant;

  logic              grant0;
  logic              grant1;
  logic              rsp_free;
  logic              exec_adv;
  logic              can_issue;
  logic              accept;
  logic              acc_id;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  alu_func_e         acc_func;
  logic              arith;
  logic [3:0]        cap_flags;

  always_comb begin
    grant0    = req0_valid && (!req1_valid || last_grant);
    grant1    = req1_valid && (!req0_valid || !last_grant);
    rsp_free  = !rsp_valid || (rsp_owner ? rsp1_ready : rsp0_ready);
    exec_adv  = exec_valid && rsp_free;
    can_issue = !exec_valid || rsp_free;
  end

  assign req0_ready = !rst && grant0 && can_issue;
  assign req1_ready = !rst && grant1 && can_issue;
  assign accept     = req0_ready || req1_ready;
  assign acc_id     = req1_ready;

  always_comb begin
    acc_a    = req0_a;
    acc_b    = req0_b;
    acc_func = alu_func_e'(req0_func);
    if (acc_id) begin
      acc_a    = req1_a;
      acc_b    = req1_b;
      acc_func = alu_func_e'(req1_func);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= acc_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_valid <= 1'b0;
      exec_a     <= '0;
      exec_b     <= '0;
      exec_func  <= ALU_ADD;
      exec_owner <= 1'b0;
    end else if (can_issue) begin
      exec_valid <= accept;
      if (accept) begin
        exec_a     <= acc_a;
        exec_b     <= acc_b;
        exec_func  <= acc_func;
        exec_owner <= acc_id;
      end
    end
  end

  assign alu_operand_a     = exec_valid ? exec_a : '0;
  assign alu_operand_b     = exec_valid ? exec_b : '0;
  assign alu_func          = exec_valid ? exec_func : ALU_ADD;
  assign alu_output_enable = exec_valid;

  // Logic ops leave carry/overflow undefined at the ALU; pin them low.
  assign arith     = (exec_func == ALU_ADD) || (exec_func == ALU_SUB);
  assign cap_flags = {alu_zero, alu_negative,
                      arith && alu_carry, arith && alu_overflow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (rsp_free) begin
        rsp_valid <= exec_valid;
      end
      if (exec_adv) begin
        rsp_owner  <= exec_owner;
        rsp_result <= alu_result;
        rsp_flags  <= cap_flags;
      end
    end
  end

  assign rsp0_valid  = rsp_valid && !rsp_owner;
  assign rsp1_valid  = rsp_valid && rsp_owner;
  assign rsp0_result = rsp_result;
  assign rsp1_result = rsp_result;
  assign rsp0_flags  = rsp_flags;
  assign rsp1_flags  = rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table vectors, hand sequences, random traffic
// checked against an in-flight FIFO model of the arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [7:0] req0_a, req0_b, rsp0_result;
  logic [2:0] req0_func;
  logic [3:0] rsp0_flags;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [7:0] req1_a, req1_b, rsp1_result;
  logic [2:0] req1_func;
  logic [3:0] rsp1_flags;
  logic [7:0] alu_operand_a, alu_operand_b, alu_result;
  logic [2:0] alu_func;
  logic       alu_output_enable;
  logic       alu_zero, alu_negative, alu_carry, alu_overflow;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_func(alu_func), .alu_output_enable(alu_output_enable),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow)
  );

  // Shared ALU; junk carry/overflow on logic ops must not leak through.
  always_comb begin
    logic [8:0] s;
    s            = '0;
    alu_carry    = 1'b1;
    alu_overflow = 1'b1;
    case (alu_func)
      3'd0: begin
        s            = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
        alu_carry    = s[8];
        alu_overflow = (alu_operand_a[7] == alu_operand_b[7]) &&
                       (s[7] != alu_operand_a[7]);
      end
      3'd1: begin
        s            = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
        alu_carry    = s[8];
        alu_overflow = (alu_operand_a[7] != alu_operand_b[7]) &&
                       (s[7] != alu_operand_a[7]);
      end
      3'd2: s[7:0] = alu_operand_a & alu_operand_b;
      3'd3: s[7:0] = alu_operand_a | alu_operand_b;
      3'd4: s[7:0] = alu_operand_a ^ alu_operand_b;
      default: s[7:0] = ~alu_operand_a;
    endcase
    alu_result   = s[7:0];
    alu_zero     = (s[7:0] == 8'h00);
    alu_negative = s[7];
  end

  always @(posedge clk) begin
    if (req0_valid) assert (req0_func <= 3'd5) else $error("req0 illegal func");
    if (req1_valid) assert (req1_func <= 3'd5) else $error("req1 illegal func");
  end

  typedef struct {
    logic       owner;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] func;
    logic [7:0] res;
    logic [3:0] flags;
    int         acc;
  } ent_t;

  ent_t q[$];
  logic lg;

  function automatic logic [11:0] ref_op(logic [2:0] f, logic [7:0] a,
                                         logic [7:0] b);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    logic [7:0] res;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 0;
    case (f)
      3'd0: begin r = ua + ub; sr = sa + sb; c = r > 255; v = sr > 127 || sr < -128; end
      3'd1: begin r = ua - ub; sr = sa - sb; c = ua < ub; v = sr > 127 || sr < -128; end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      default: r = 255 - ua;
    endcase
    res = 8'(r);
    return {res, res == 8'h00, res[7], c, v};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  // Inputs are set at the negedge; check, update the model, advance one cycle.
  task automatic tick();
    bit in_rsp, exec_v, drain, g0, g1, ci;
    ent_t e;
    logic [11:0] r;
    #1;
    if (rst) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_alu_oe", alu_output_enable, 0);
      chk("rst_rsp_result", rsp0_result, 0);
      chk("rst_rsp_flags", rsp1_flags, 0);
      chk("rst_alu_a", alu_operand_a, 0);
      q.delete();
      lg = 1'b1;
    end else begin
      in_rsp = q.size() > 0 && cyc >= q[0].acc + 2;
      exec_v = q.size() == 2 || (q.size() == 1 && !in_rsp);
      drain  = in_rsp && (q[0].owner ? rsp1_ready : rsp0_ready);
      ci     = q.size() < 2 || drain;
      g0     = req0_valid && (!req1_valid || lg);
      g1     = req1_valid && (!req0_valid || !lg);
      chk("req0_ready", req0_ready, g0 && ci);
      chk("req1_ready", req1_ready, g1 && ci);
      chk("rsp0_valid", rsp0_valid, in_rsp && !q[0].owner);
      chk("rsp1_valid", rsp1_valid, in_rsp && q[0].owner);
      if (in_rsp) begin
        chk("rsp_result", q[0].owner ? rsp1_result : rsp0_result, q[0].res);
        chk("rsp_flags", q[0].owner ? rsp1_flags : rsp0_flags, q[0].flags);
      end
      chk("alu_oe", alu_output_enable, exec_v);
      if (exec_v) begin
        e = q[q.size()-1];
        chk("alu_a", alu_operand_a, e.a);
        chk("alu_b", alu_operand_b, e.b);
        chk("alu_func", alu_func, e.func);
      end else begin
        chk("alu_idle", {alu_operand_a, alu_operand_b, alu_func}, 0);
      end
      if (drain) void'(q.pop_front());
      if (ci && (g0 || g1)) begin
        e.owner = g1;
        e.a     = g1 ? req1_a : req0_a;
        e.b     = g1 ? req1_b : req0_b;
        e.func  = g1 ? req1_func : req0_func;
        r       = ref_op(e.func, e.a, e.b);
        e.res   = r[11:4];
        e.flags = r[3:0];
        e.acc   = cyc;
        q.push_back(e);
        lg      = g1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(int r, bit v, logic [2:0] f, logic [7:0] a,
                         logic [7:0] b);
    if (r == 0) begin
      req0_valid = v; req0_func = f; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_func = f; req1_a = a; req1_b = b;
    end
  endtask

  task automatic rnd_req(int r, bit v);
    set_req(r, v, 3'($urandom_range(5)), 8'($urandom), 8'($urandom));
  endtask

  typedef struct {
    logic [2:0] func;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{3'd0, 8'hF0, 8'h20, 8'h10, 4'b0010};
    tbl[1] = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
    tbl[2] = '{3'd2, 8'h0F, 8'hF0, 8'h00, 4'b1000};
    tbl[3] = '{3'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0100};
    tbl[4] = '{3'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    tbl[5] = '{3'd5, 8'h00, 8'h55, 8'hFF, 4'b0100};
    tbl[6] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
    tbl[7] = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b0110};
    tbl[8] = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010};
    tbl[9] = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b1000};

    rst = 1'b1;
    lg  = 1'b1;
    set_req(0, 0, 3'd0, 8'h00, 8'h00);
    set_req(1, 0, 3'd0, 8'h00, 8'h00);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_req(i % 2, 1, tbl[i].func, tbl[i].a, tbl[i].b);
      tick();
      set_req(i % 2, 0, 3'd0, 8'h00, 8'h00);
      tick();
      chk("tbl_valid", (i % 2) ? rsp1_valid : rsp0_valid, 1);
      chk("tbl_result", (i % 2) ? rsp1_result : rsp0_result, tbl[i].res);
      chk("tbl_flags", (i % 2) ? rsp1_flags : rsp0_flags, tbl[i].flags);
      tick();
    end

    for (int i = 0; i < 12; i++) begin
      rnd_req(0, 1);
      rnd_req(1, 1);
      if (i >= 3) chk("no_bubble", rsp0_valid || rsp1_valid, 1);
      tick();
    end
    set_req(0, 0, 3'd0, 8'h00, 8'h00);
    set_req(1, 0, 3'd0, 8'h00, 8'h00);
    tick();
    tick();

    rsp0_ready = 1'b0;
    set_req(0, 1, 3'd0, 8'h01, 8'h02);
    tick();
    set_req(0, 1, 3'd1, 8'h09, 8'h03);
    tick();
    set_req(0, 1, 3'd2, 8'h3C, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", rsp0_result, 8'h03);
      tick();
    end
    rsp0_ready = 1'b1;
    set_req(0, 0, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    set_req(0, 1, 3'd0, 8'h11, 8'h22);
    tick();
    set_req(0, 0, 3'd0, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rnd_req(0, 1);
    rnd_req(1, 1);
    tick();
    set_req(0, 0, 3'd0, 8'h00, 8'h00);
    set_req(1, 0, 3'd0, 8'h00, 8'h00);
    tick();
    tick();

    for (int i = 0; i < 600; i++) begin
      rnd_req(0, $urandom_range(9) < 7);
      rnd_req(1, $urandom_range(9) < 6);
      rsp0_ready = $urandom_range(3) != 0;
      rsp1_ready = $urandom_range(3) != 0;
      tick();
    end

    set_req(0, 0, 3'd0, 8'h00, 8'h00);
    set_req(1, 0, 3'd0, 8'h00, 8'h00);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
